avm_dual_master_arbiter: RTL



---
 rtl/avm_dual_master_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/avm_dual_master_arbiter.sv
// rtl/avm_dual_master_arbiter.sv - two-master Avalon-MM burst arbiter; define AVM_ARB_ROUND_ROBIN_EN for round-robin ties
module avm_dual_master_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BCW = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [AW-1:0]   m0_address,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [BCW-1:0]  m0_burstcount,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,

    input  logic [AW-1:0]   m1_address,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [BCW-1:0]  m1_burstcount,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,

    output logic [AW-1:0]   s_address,
    output logic [DW/8-1:0] s_byteenable,
    output logic [DW-1:0]   s_writedata,
    output logic [BCW-1:0]  s_burstcount,
    output logic            s_read,
    output logic            s_write,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid
);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

    localparam logic [BCW-1:0] ONE = BCW'(1);

    state_t         state, state_nxt;
    logic           gnt, gnt_nxt;
    logic [BCW-1:0] blen, blen_nxt;
    logic [BCW-1:0] cnt, cnt_nxt;

    logic           req0, req1, sel, sel_rd;
    logic [BCW-1:0] sel_bc;
    logic           cmd_phase, rd_phase, last_beat;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // sel: 0 = m0, 1 = m1; only meaningful when some master requests
`ifdef AVM_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (state == IDLE && (req0 || req1))
            last_gnt <= sel;
    end

    assign sel = (req0 && req1) ? ~last_gnt : req1;
`else
    assign sel = ~req0;
`endif

    assign sel_rd    = sel ? m1_read : m0_read;
    assign sel_bc    = sel ? m1_burstcount : m0_burstcount;
    assign last_beat = (cnt == blen - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            blen  <= ONE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            blen  <= blen_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        blen_nxt  = blen;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0 || req1) begin
                    gnt_nxt   = sel;
                    blen_nxt  = (sel_bc == '0) ? ONE : sel_bc;
                    state_nxt = sel_rd ? RD_CMD : WR;
                end
            end
            RD_CMD: begin
                // a zero-latency slave may return beat 0 on the acceptance cycle
                if (!s_waitrequest) begin
                    if (s_readdatavalid) begin
                        if (blen == ONE) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = RD_DATA;
                            cnt_nxt   = ONE;
                        end
                    end else begin
                        state_nxt = RD_DATA;
                        cnt_nxt   = '0;
                    end
                end
            end
            RD_DATA: begin
                if (s_readdatavalid) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            WR: begin
                if (!s_waitrequest) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_phase = (state == RD_CMD) || (state == WR);
    assign rd_phase  = (state == RD_CMD) || (state == RD_DATA);

    assign s_address    = gnt ? m1_address    : m0_address;
    assign s_byteenable = gnt ? m1_byteenable : m0_byteenable;
    assign s_writedata  = gnt ? m1_writedata  : m0_writedata;
    assign s_burstcount = gnt ? m1_burstcount : m0_burstcount;
    assign s_read       = (state == RD_CMD);
    assign s_write      = (state == WR);

    assign m0_waitrequest = (cmd_phase && !gnt) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (cmd_phase &&  gnt) ? s_waitrequest : 1'b1;

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // beats arriving outside a read burst are stale and must not reach either master
    assign m0_readdatavalid = s_readdatavalid && rd_phase && !gnt;
    assign m1_readdatavalid = s_readdatavalid && rd_phase &&  gnt;

endmodule
